uart_rx: RTL and testbench
==========================

# uart_rx

Serial-to-parallel UART receiver: 8N1 framing (optional even parity), LSB first, fixed baud set by `clocksPerBit`. Synchronises the asynchronous `serialDataInput` pin, qualifies the start bit at mid-bit, samples each bit at its centre and presents the assembled byte with a one-cycle valid strobe. It is the receive end of the link driven by the team's UART transmitter and feeds the command/packet logic in the same clock domain.

## Interface
- `clocksPerBit`, 108: system clocks per serial bit; legal range 4..65535.
- `systemClock`  input  1  system clock; all logic on rising edge.
- `systemReset`  input  1  asynchronous, active-high reset.
- `serialDataInput`  input  1  asynchronous serial line; idles high.
- `receivedByte`  output  8  last correctly framed byte; held until the next good frame.
- `receiveDataValid`  output  1  one-cycle pulse when `receivedByte` updates.
- `isReceiveActive`  output  1  high from start-bit qualification until the end of the stop-bit sample.
- `framingError`  output  1  one-cycle pulse when the stop bit samples low.
- `parityError`  output  1  one-cycle pulse on parity mismatch; constant 0 when parity is compiled out.

## Operation
- Input passes through a two-flop synchroniser (reset value 1); the FSM sees only the synchronised line `rxSync`.
- A 16-bit cycle counter, a 3-bit bit index and an 8-bit shift buffer.
- States: IDLE, START, DATA, PARITY (present only when parity is compiled in), STOP, WAIT_HIGH.
- IDLE:
  - counter = 0, index = 0.
  - `rxSync` == 0 -> START.
- START:
  - Count to `(clocksPerBit-1)/2`.
  - At the terminal count, `rxSync` == 0 -> DATA with counter cleared, `isReceiveActive` set.
  - At the terminal count, `rxSync` == 1 -> glitch; return to IDLE with no outputs.
- DATA:
  - Count to `clocksPerBit-1`; at the terminal count, sample `rxSync` into `buffer[index]`.
  - After index 7 -> PARITY or STOP, otherwise index+1.
- PARITY:
  - At `clocksPerBit-1`, compare the sample with the XOR of the buffer (even parity).
  - Latch the mismatch internally, then go to STOP.
- STOP:
  - At `clocksPerBit-1`, sample the stop bit.
  - Stop = 1 and no parity mismatch: load `receivedByte`, pulse `receiveDataValid`.
  - Stop = 1 with a parity mismatch: pulse `parityError` only; `receivedByte` is unchanged.
  - Stop = 0: pulse `framingError`; no valid strobe; go to WAIT_HIGH.
  - Stop = 1: go to IDLE.
  - In all cases, clear `isReceiveActive`.
- WAIT_HIGH: stay until `rxSync` == 1, then go to IDLE. This prevents a break condition from being decoded as repeated 0x00 frames.
- An illegal state encoding -> IDLE.
- Reset (any time, including mid-frame):
  - Outputs: `receivedByte` = 0x00, all strobes 0, `isReceiveActive` = 0.
  - Internals: FSM = IDLE, counter, index and buffer = 0, synchroniser flops = 1.
  - A partial frame is discarded silently.

## Timing
- Start detection: 2 cycles of synchroniser latency after the pin falls, +1 cycle to enter START.
- Valid latency: `receiveDataValid` asserts in the cycle after the stop-bit sample, about 3 + `(clocksPerBit-1)/2` + 9·`clocksPerBit` cycles after the pin's falling edge (+`clocksPerBit` with parity).
- Every strobe is exactly 1 cycle wide. At most one of `receiveDataValid`, `framingError` and `parityError` is high in any cycle.
- Back-to-back frames: after a good stop, IDLE re-arms. A start edge arriving half a bit after the stop sample is captured; no dead time is required beyond the stop bit.
- Tolerance: sampling at mid-bit accepts about ±4% baud mismatch over 10 bits.

## Configuration
- `UART_RX_PARITY_EN` defined:
  - PARITY state exists; frame is 11 bits (start, 8 data, even parity, stop).
  - `parityError` is live.
- `UART_RX_PARITY_EN` undefined:
  - 10-bit 8N1 frame; PARITY state omitted.
  - `parityError` tied to 0.
- The port list is identical in both builds.

## Structure
- `uart_pkg`: state enum `uart_rx_state_t`, `UART_DATA_BITS` = 8, and the shared default `UART_CLOCKS_PER_BIT` = 108 (also referenced by the transmitter).
- Sub-module `uart_rx_sync`: two-flop synchroniser with async preset to 1, reused for any other async inputs.

## Test plan
- `clocksPerBit` = 16, frame 0xA5 sent with the transmitter -> one `receiveDataValid` pulse, `receivedByte` = 0xA5, no error strobes.
- Back-to-back 0x00 then 0xFF with no idle gap -> two valid pulses, bytes 0x00 then 0xFF, in order.
- Low glitch of 5 cycles (less than half a bit at `clocksPerBit` = 16) -> FSM returns to IDLE; no strobes, `isReceiveActive` never rises.
- Frame 0x3C with the stop bit forced low, then the line held low for 40 cycles -> one `framingError` pulse, `receivedByte` keeps its prior value, no new frame decoded until the line goes high.
- `systemReset` asserted at data bit 4 of 0x5A, then released, then 0x81 sent -> outputs reset to 0 immediately, then one valid pulse with 0x81.
- With `UART_RX_PARITY_EN`: 0x07 with parity bit 1 -> valid; 0x07 with parity bit 0 -> `parityError` pulse, no valid.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions for the receiver and transmitter.
// Holds the receiver state encoding, the data width and the default
// baud divisor. The optional even-parity build is selected with the
// UART_RX_PARITY_EN macro in the receiver itself.
package uart_pkg;

  localparam int UART_DATA_BITS      = 8;
  localparam int UART_CLOCKS_PER_BIT = 108;

  typedef enum logic [2:0] {
    UART_RX_IDLE      = 3'd0,
    UART_RX_START     = 3'd1,
    UART_RX_DATA      = 3'd2,
    UART_RX_PARITY    = 3'd3,
    UART_RX_STOP      = 3'd4,
    UART_RX_WAIT_HIGH = 3'd5
  } uart_rx_state_t;

  // Even parity of a data word: the parity bit that makes the total count of ones even
  function automatic logic evenParity(input logic [UART_DATA_BITS-1:0] dataWord);
    return ^dataWord;
  endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchroniser for an asynchronous single-bit input.
// Both flops preset to 1 so an idle-high serial line looks idle
// straight out of reset and no false start bit is seen.
module uart_rx_sync (
  input  logic systemClock,
  input  logic systemReset,
  input  logic asyncLine,
  output logic syncLine
);

  logic firstStage;

  // Shift the raw line through two flops to settle any metastability
  always_ff @(posedge systemClock or posedge systemReset) begin
    if (systemReset) begin
      firstStage <= 1'b1;
      syncLine   <= 1'b1;
    end else begin
      firstStage <= asyncLine;
      syncLine   <= firstStage;
    end
  end

endmodule

// File: rtl/uart_rx.sv
// UART receiver: 8 data bits, LSB first, one stop bit, fixed baud.
// The start bit is qualified at mid-bit and every later bit is sampled
// at its centre. Define UART_RX_PARITY_EN to add an even-parity bit
// between the data and stop bits; otherwise parityError is tied low.
module uart_rx
  import uart_pkg::*;
#(
  parameter int clocksPerBit = UART_CLOCKS_PER_BIT
) (
  input  logic                      systemClock,
  input  logic                      systemReset,
  input  logic                      serialDataInput,
  output logic [UART_DATA_BITS-1:0] receivedByte,
  output logic                      receiveDataValid,
  output logic                      isReceiveActive,
  output logic                      framingError,
  output logic                      parityError
);

  localparam logic [2:0] ST_IDLE      = UART_RX_IDLE;
  localparam logic [2:0] ST_START     = UART_RX_START;
  localparam logic [2:0] ST_DATA      = UART_RX_DATA;
  localparam logic [2:0] ST_STOP      = UART_RX_STOP;
  localparam logic [2:0] ST_WAIT_HIGH = UART_RX_WAIT_HIGH;
`ifdef UART_RX_PARITY_EN
  localparam logic [2:0] ST_PARITY    = UART_RX_PARITY;
  localparam logic [2:0] ST_AFTER_DATA = ST_PARITY;
`else
  localparam logic [2:0] ST_AFTER_DATA = ST_STOP;
`endif

  localparam logic [15:0] HALF_COUNT = 16'((clocksPerBit - 1) / 2);
  localparam logic [15:0] FULL_COUNT = 16'(clocksPerBit - 1);
  localparam logic [2:0]  LAST_INDEX = 3'(UART_DATA_BITS - 1);

  logic                      rxSync;
  logic [2:0]                state;
  logic [15:0]               bitCounter;
  logic [2:0]                bitIndex;
  logic [UART_DATA_BITS-1:0] shiftBuffer;
`ifdef UART_RX_PARITY_EN
  logic                      parityMismatch;
`endif

  uart_rx_sync lineSync (
    .systemClock (systemClock),
    .systemReset (systemReset),
    .asyncLine   (serialDataInput),
    .syncLine    (rxSync)
  );

  // Frame FSM: qualifies the start bit, samples each bit at its centre and raises one-cycle result strobes
  always_ff @(posedge systemClock or posedge systemReset) begin
    if (systemReset) begin
      state            <= ST_IDLE;
      bitCounter       <= 16'd0;
      bitIndex         <= 3'd0;
      shiftBuffer      <= '0;
      receivedByte     <= '0;
      receiveDataValid <= 1'b0;
      isReceiveActive  <= 1'b0;
      framingError     <= 1'b0;
`ifdef UART_RX_PARITY_EN
      parityError      <= 1'b0;
      parityMismatch   <= 1'b0;
`endif
    end else begin
      receiveDataValid <= 1'b0;
      framingError     <= 1'b0;
`ifdef UART_RX_PARITY_EN
      parityError      <= 1'b0;
`endif
      case (state)
        ST_IDLE: begin
          bitCounter <= 16'd0;
          bitIndex   <= 3'd0;
`ifdef UART_RX_PARITY_EN
          parityMismatch <= 1'b0;
`endif
          if (!rxSync) begin
            state <= ST_START;
          end
        end

        ST_START: begin
          if (bitCounter == HALF_COUNT) begin
            bitCounter <= 16'd0;
            if (!rxSync) begin
              state           <= ST_DATA;
              isReceiveActive <= 1'b1;
            end else begin
              state <= ST_IDLE;
            end
          end else begin
            bitCounter <= bitCounter + 16'd1;
          end
        end

        ST_DATA: begin
          if (bitCounter == FULL_COUNT) begin
            bitCounter            <= 16'd0;
            shiftBuffer[bitIndex] <= rxSync;
            if (bitIndex == LAST_INDEX) begin
              bitIndex <= 3'd0;
              state    <= ST_AFTER_DATA;
            end else begin
              bitIndex <= bitIndex + 3'd1;
            end
          end else begin
            bitCounter <= bitCounter + 16'd1;
          end
        end

`ifdef UART_RX_PARITY_EN
        ST_PARITY: begin
          if (bitCounter == FULL_COUNT) begin
            bitCounter     <= 16'd0;
            parityMismatch <= (rxSync != evenParity(shiftBuffer));
            state          <= ST_STOP;
          end else begin
            bitCounter <= bitCounter + 16'd1;
          end
        end
`endif

        ST_STOP: begin
          if (bitCounter == FULL_COUNT) begin
            bitCounter      <= 16'd0;
            isReceiveActive <= 1'b0;
            if (rxSync) begin
              state <= ST_IDLE;
`ifdef UART_RX_PARITY_EN
              if (parityMismatch) begin
                parityError <= 1'b1;
              end else begin
                receivedByte     <= shiftBuffer;
                receiveDataValid <= 1'b1;
              end
`else
              receivedByte     <= shiftBuffer;
              receiveDataValid <= 1'b1;
`endif
            end else begin
              framingError <= 1'b1;
              state        <= ST_WAIT_HIGH;
            end
          end else begin
            bitCounter <= bitCounter + 16'd1;
          end
        end

        ST_WAIT_HIGH: begin
          if (rxSync) begin
            state <= ST_IDLE;
          end
        end

        default: begin
          state           <= ST_IDLE;
          bitCounter      <= 16'd0;
          bitIndex        <= 3'd0;
          isReceiveActive <= 1'b0;
        end
      endcase
    end
  end

`ifndef UART_RX_PARITY_EN
  assign parityError = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx.sv
// Directed testbench for uart_rx at 16 clocks per bit.
// Frames are driven bit by bit on the falling clock edge; a monitor
// records strobes and received bytes, and each test task compares the
// recorded activity against hand-computed expectations.
module tb_uart_rx;

  localparam int CPB = 16;

  logic       systemClock = 1'b0;
  logic       systemReset = 1'b1;
  logic       serialDataInput = 1'b1;
  logic [7:0] receivedByte;
  logic       receiveDataValid;
  logic       isReceiveActive;
  logic       framingError;
  logic       parityError;

  int vectorCount = 0;
  int missCount = 0;

  int validCount = 0;
  int framingCount = 0;
  int parityCount = 0;
  int overlapCount = 0;
  bit activeSeen = 1'b0;
  logic [7:0] byteLog[$];

  uart_rx #(.clocksPerBit(CPB)) dut (
    .systemClock      (systemClock),
    .systemReset      (systemReset),
    .serialDataInput  (serialDataInput),
    .receivedByte     (receivedByte),
    .receiveDataValid (receiveDataValid),
    .isReceiveActive  (isReceiveActive),
    .framingError     (framingError),
    .parityError      (parityError)
  );

  // Free-running system clock, 10 time units per period
  always #5 systemClock = ~systemClock;

  // Record strobes and received bytes half a cycle after each active edge
  always @(negedge systemClock) begin
    if (!systemReset) begin
      if (receiveDataValid) begin
        validCount++;
        byteLog.push_back(receivedByte);
      end
      if (framingError) framingCount++;
      if (parityError) parityCount++;
      if (isReceiveActive) activeSeen = 1'b1;
      if ((int'(receiveDataValid) + int'(framingError) + int'(parityError)) > 1) overlapCount++;
    end
  end

  task automatic clearMonitor();
    @(posedge systemClock);
    validCount = 0;
    framingCount = 0;
    parityCount = 0;
    activeSeen = 1'b0;
    byteLog.delete();
    @(negedge systemClock);
  endtask

  task automatic applyStimulus(input logic lineValue, input int cycles);
    serialDataInput = lineValue;
    repeat (cycles) @(negedge systemClock);
  endtask

  task automatic sendFrame(input logic [7:0] dataWord, input logic stopBit);
    applyStimulus(1'b0, CPB);
    for (int i = 0; i < 8; i++) applyStimulus(dataWord[i], CPB);
`ifdef UART_RX_PARITY_EN
    applyStimulus(^dataWord, CPB);
`endif
    applyStimulus(stopBit, CPB);
  endtask

  task automatic test_reset();
    systemReset = 1'b1;
    serialDataInput = 1'b1;
    repeat (3) @(negedge systemClock);
    vectorCount++;
    if (receivedByte !== 8'h00) begin missCount++; $display("[TB] FAIL reset_byte: got %0h expected 00", receivedByte); end
    vectorCount++;
    if (receiveDataValid !== 1'b0) begin missCount++; $display("[TB] FAIL reset_valid: got %0b expected 0", receiveDataValid); end
    vectorCount++;
    if (isReceiveActive !== 1'b0) begin missCount++; $display("[TB] FAIL reset_active: got %0b expected 0", isReceiveActive); end
    vectorCount++;
    if (framingError !== 1'b0) begin missCount++; $display("[TB] FAIL reset_framing: got %0b expected 0", framingError); end
    vectorCount++;
    if (parityError !== 1'b0) begin missCount++; $display("[TB] FAIL reset_parity: got %0b expected 0", parityError); end
    systemReset = 1'b0;
    repeat (10) @(negedge systemClock);
    vectorCount++;
    if (isReceiveActive !== 1'b0) begin missCount++; $display("[TB] FAIL idle_active: got %0b expected 0", isReceiveActive); end
  endtask

  task automatic test_basic_frame();
    clearMonitor();
    sendFrame(8'hA5, 1'b1);
    applyStimulus(1'b1, 20);
    vectorCount++;
    if (validCount !== 1) begin missCount++; $display("[TB] FAIL basic_valid_count: got %0d expected 1", validCount); end
    vectorCount++;
    if (receivedByte !== 8'hA5) begin missCount++; $display("[TB] FAIL basic_byte: got %0h expected a5", receivedByte); end
    vectorCount++;
    if (byteLog.size() != 1 || byteLog[0] !== 8'hA5) begin missCount++; $display("[TB] FAIL basic_strobe_byte: got %0d entries expected 1 entry a5", byteLog.size()); end
    vectorCount++;
    if (framingCount !== 0 || parityCount !== 0) begin missCount++; $display("[TB] FAIL basic_errors: got framing %0d parity %0d expected 0 0", framingCount, parityCount); end
    vectorCount++;
    if (activeSeen !== 1'b1) begin missCount++; $display("[TB] FAIL basic_active_seen: got %0b expected 1", activeSeen); end
    vectorCount++;
    if (isReceiveActive !== 1'b0) begin missCount++; $display("[TB] FAIL basic_active_after: got %0b expected 0", isReceiveActive); end
  endtask

  task automatic test_back_to_back();
    clearMonitor();
    sendFrame(8'h00, 1'b1);
    sendFrame(8'hFF, 1'b1);
    applyStimulus(1'b1, 20);
    vectorCount++;
    if (validCount !== 2) begin missCount++; $display("[TB] FAIL b2b_valid_count: got %0d expected 2", validCount); end
    vectorCount++;
    if (byteLog.size() < 1 || byteLog[0] !== 8'h00) begin missCount++; $display("[TB] FAIL b2b_first_byte: got %0d entries expected first 00", byteLog.size()); end
    vectorCount++;
    if (byteLog.size() < 2 || byteLog[1] !== 8'hFF) begin missCount++; $display("[TB] FAIL b2b_second_byte: got %0d entries expected second ff", byteLog.size()); end
    vectorCount++;
    if (overlapCount !== 0) begin missCount++; $display("[TB] FAIL strobe_overlap: got %0d expected 0", overlapCount); end
  endtask

  task automatic test_glitch();
    clearMonitor();
    applyStimulus(1'b0, 5);
    applyStimulus(1'b1, 40);
    vectorCount++;
    if (validCount !== 0 || framingCount !== 0 || parityCount !== 0) begin missCount++; $display("[TB] FAIL glitch_strobes: got valid %0d framing %0d parity %0d expected 0 0 0", validCount, framingCount, parityCount); end
    vectorCount++;
    if (activeSeen !== 1'b0) begin missCount++; $display("[TB] FAIL glitch_active: got %0b expected 0", activeSeen); end
    vectorCount++;
    if (receivedByte !== 8'hFF) begin missCount++; $display("[TB] FAIL glitch_byte_held: got %0h expected ff", receivedByte); end
  endtask

  task automatic test_framing_error();
    clearMonitor();
    sendFrame(8'h3C, 1'b0);
    applyStimulus(1'b0, 40);
    vectorCount++;
    if (framingCount !== 1) begin missCount++; $display("[TB] FAIL framing_count: got %0d expected 1", framingCount); end
    vectorCount++;
    if (validCount !== 0) begin missCount++; $display("[TB] FAIL framing_no_valid: got %0d expected 0", validCount); end
    vectorCount++;
    if (receivedByte !== 8'hFF) begin missCount++; $display("[TB] FAIL framing_byte_held: got %0h expected ff", receivedByte); end
    vectorCount++;
    if (isReceiveActive !== 1'b0) begin missCount++; $display("[TB] FAIL framing_active: got %0b expected 0", isReceiveActive); end
    applyStimulus(1'b1, 20);
    clearMonitor();
    sendFrame(8'h11, 1'b1);
    applyStimulus(1'b1, 20);
    vectorCount++;
    if (validCount !== 1 || receivedByte !== 8'h11) begin missCount++; $display("[TB] FAIL framing_recovery: got %0d valid byte %0h expected 1 valid byte 11", validCount, receivedByte); end
  endtask

  task automatic test_reset_mid_frame();
    logic [7:0] partial;
    partial = 8'h5A;
    clearMonitor();
    applyStimulus(1'b0, CPB);
    for (int i = 0; i < 4; i++) applyStimulus(partial[i], CPB);
    applyStimulus(partial[4], CPB / 2);
    systemReset = 1'b1;
    #1;
    vectorCount++;
    if (receivedByte !== 8'h00) begin missCount++; $display("[TB] FAIL midreset_byte: got %0h expected 00", receivedByte); end
    vectorCount++;
    if (isReceiveActive !== 1'b0) begin missCount++; $display("[TB] FAIL midreset_active: got %0b expected 0", isReceiveActive); end
    serialDataInput = 1'b1;
    repeat (3) @(negedge systemClock);
    systemReset = 1'b0;
    applyStimulus(1'b1, 20);
    clearMonitor();
    sendFrame(8'h81, 1'b1);
    applyStimulus(1'b1, 20);
    vectorCount++;
    if (validCount !== 1) begin missCount++; $display("[TB] FAIL midreset_valid_count: got %0d expected 1", validCount); end
    vectorCount++;
    if (receivedByte !== 8'h81) begin missCount++; $display("[TB] FAIL midreset_byte_after: got %0h expected 81", receivedByte); end
    vectorCount++;
    if (framingCount !== 0 || parityCount !== 0) begin missCount++; $display("[TB] FAIL midreset_errors: got framing %0d parity %0d expected 0 0", framingCount, parityCount); end
  endtask

`ifdef UART_RX_PARITY_EN
  task automatic sendParityFrame(input logic [7:0] dataWord, input logic parityBit);
    applyStimulus(1'b0, CPB);
    for (int i = 0; i < 8; i++) applyStimulus(dataWord[i], CPB);
    applyStimulus(parityBit, CPB);
    applyStimulus(1'b1, CPB);
  endtask

  task automatic test_parity();
    clearMonitor();
    sendParityFrame(8'h07, 1'b1);
    applyStimulus(1'b1, 20);
    vectorCount++;
    if (validCount !== 1 || receivedByte !== 8'h07) begin missCount++; $display("[TB] FAIL parity_good: got %0d valid byte %0h expected 1 valid byte 07", validCount, receivedByte); end
    vectorCount++;
    if (parityCount !== 0) begin missCount++; $display("[TB] FAIL parity_good_err: got %0d expected 0", parityCount); end
    clearMonitor();
    sendParityFrame(8'h07, 1'b0);
    applyStimulus(1'b1, 20);
    vectorCount++;
    if (parityCount !== 1) begin missCount++; $display("[TB] FAIL parity_bad_err: got %0d expected 1", parityCount); end
    vectorCount++;
    if (validCount !== 0) begin missCount++; $display("[TB] FAIL parity_bad_valid: got %0d expected 0", validCount); end
  endtask
`endif

  // Run every scenario in order, then report
  initial begin
    test_reset();
    test_basic_frame();
    test_back_to_back();
    test_glitch();
    test_framing_error();
    test_reset_mid_frame();
`ifdef UART_RX_PARITY_EN
    test_parity();
`endif
    vectorCount++;
    if (overlapCount !== 0) begin missCount++; $display("[TB] FAIL final_overlap: got %0d expected 0", overlapCount); end
    $display("== %0d vectors applied, %0d miscompares ==", vectorCount, missCount);
    $finish;
  end

endmodule
